pwm_capture: RTL and testbench

- Downstream consumer of the PWM generator output. Measures the pulse high-time and full period of a PWM waveform in clk1ms ticks.
- Publishes each completed measurement with a 1-cycle valid strobe.
- Flags loss-of-signal (timeout) when no complete period arrives in time.
- Used for loop-back checking of the PWM stage and for decoding servo-style (20 ms period) control signals.

---
 rtl/pwm_capture.sv | 153 +++++++++++++++
 tb/tb_pwm_capture.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM high-time and period (rise to rise) in clk1ms ticks.
//
// Ports
//   clk1ms        in   1 ms tick clock, rising edge
//   reset         in   asynchronous, active-high reset
//   pwm_in        in   PWM waveform, may be asynchronous to clk1ms
//   high_ticks    out  high-time of the last completed period
//   period_ticks  out  length of the last completed period
//   meas_valid    out  1-cycle strobe, high_ticks/period_ticks updated
//   timeout       out  sticky loss-of-signal flag, cleared by the next measurement
//   state         out  FSM state for debug (SEEK=00, HIGH=01, LOW=10)
//
// Build option
//   PWM_CAPTURE_GLITCH_FILTER_EN  adds a 2-sample agreement filter after the
//                                 synchronizer; single-tick pulses and dropouts
//                                 are ignored and latency grows by one edge.
module pwm_capture #(
   parameter int unsigned        CNT_W   = 8,
   parameter logic [CNT_W-1:0]   TIMEOUT = CNT_W'(100)
) (
   input  logic             clk1ms,
   input  logic             reset,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_ticks,
   output logic [CNT_W-1:0] period_ticks,
   output logic             meas_valid,
   output logic             timeout,
   output logic [1:0]       state
);

   localparam logic [1:0] SEEK = 2'b00;
   localparam logic [1:0] HIGH = 2'b01;
   localparam logic [1:0] LOW  = 2'b10;

   logic sync1, s, s_d;
   logic lvl, lvl_d, rise, fall;

   // 2-flop synchronizer plus delay; reset to 1 so a line already high is no edge
   always_ff @(posedge clk1ms or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         s     <= 1'b1;
         s_d   <= 1'b1;
      end else begin
         sync1 <= pwm_in;
         s     <= sync1;
         s_d   <= s;
      end
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   logic filt;

   // Level only moves once two consecutive synchronized samples agree
   assign lvl   = (s == s_d) ? s : filt;
   assign lvl_d = filt;

   always_ff @(posedge clk1ms or posedge reset) begin
      if (reset) filt <= 1'b1;
      else       filt <= lvl;
   end
`else
   assign lvl   = s;
   assign lvl_d = s_d;
`endif

   assign rise = lvl & ~lvl_d;
   assign fall = ~lvl & lvl_d;

   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] hi_cnt, per_cnt, hi_nxt, per_nxt;
   logic [CNT_W-1:0] high_nxt, period_nxt;
   logic             valid_nxt, timeout_nxt;

   // State and output registers
   always_ff @(posedge clk1ms or posedge reset) begin
      if (reset) begin
         state        <= SEEK;
         hi_cnt       <= '0;
         per_cnt      <= '0;
         high_ticks   <= '0;
         period_ticks <= '0;
         meas_valid   <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         state        <= state_nxt;
         hi_cnt       <= hi_nxt;
         per_cnt      <= per_nxt;
         high_ticks   <= high_nxt;
         period_ticks <= period_nxt;
         meas_valid   <= valid_nxt;
         timeout      <= timeout_nxt;
      end
   end

   // Next-state and output logic; a rise beats a simultaneous timeout
   always_comb begin
      state_nxt   = state;
      hi_nxt      = hi_cnt;
      per_nxt     = per_cnt;
      high_nxt    = high_ticks;
      period_nxt  = period_ticks;
      valid_nxt   = 1'b0;
      timeout_nxt = timeout;
      case (state)
         SEEK: begin
            if (rise) begin
               hi_nxt    = CNT_W'(1);
               per_nxt   = CNT_W'(1);
               state_nxt = HIGH;
            end
         end
         HIGH: begin
            if (per_cnt == TIMEOUT) begin
               timeout_nxt = 1'b1;
               hi_nxt      = '0;
               per_nxt     = '0;
               state_nxt   = SEEK;
            end else if (fall) begin
               per_nxt   = per_cnt + CNT_W'(1);
               state_nxt = LOW;
            end else begin
               hi_nxt  = hi_cnt + CNT_W'(1);
               per_nxt = per_cnt + CNT_W'(1);
            end
         end
         LOW: begin
            if (rise) begin
               high_nxt    = hi_cnt;
               period_nxt  = per_cnt;
               valid_nxt   = 1'b1;
               timeout_nxt = 1'b0;
               hi_nxt      = CNT_W'(1);
               per_nxt     = CNT_W'(1);
               state_nxt   = HIGH;
            end else if (per_cnt == TIMEOUT) begin
               timeout_nxt = 1'b1;
               hi_nxt      = '0;
               per_nxt     = '0;
               state_nxt   = SEEK;
            end else begin
               per_nxt = per_cnt + CNT_W'(1);
            end
         end
         default: begin
            hi_nxt    = '0;
            per_nxt   = '0;
            state_nxt = SEEK;
         end
      endcase
   end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized and directed checks of pwm_capture against an
// event-level model (rise/fall tick indices -> expected measurements).
module tb_pwm_capture;

   localparam int TMO = 100;

   logic       clk1ms = 1'b0;
   logic       reset  = 1'b1;
   logic       pwm_in = 1'b1;
   logic [7:0] high_ticks, period_ticks;
   logic       meas_valid, timeout;
   logic [1:0] state;

   pwm_capture #(.CNT_W(8), .TIMEOUT(8'd100)) dut (
      .clk1ms      (clk1ms),
      .reset       (reset),
      .pwm_in      (pwm_in),
      .high_ticks  (high_ticks),
      .period_ticks(period_ticks),
      .meas_valid  (meas_valid),
      .timeout     (timeout),
      .state       (state)
   );

   always #5 clk1ms = ~clk1ms;

   int tests = 0;
   int fails = 0;

   // Model: history of sampled pwm values, level seen by the measurement,
   // tick indices of the last rise/fall, and phase (0 idle, 1 high, 2 low).
   bit         h1, h2, h3, lprev;
   int         n, rise_n, fall_n, phase;
   logic [7:0] e_high, e_period;
   bit         e_valid, e_tmo;

   int         valid_seen;
   logic [7:0] first_hi, first_per, last_hi, last_per;
   int         saw_short;

   task automatic model_reset();
      h1 = 1; h2 = 1; h3 = 1; lprev = 1;
      n = 0; rise_n = 0; fall_n = 0; phase = 0;
      e_high = 0; e_period = 0; e_valid = 0; e_tmo = 0;
   endtask

   task automatic model_step(input bit x);
      bit lvl, rs, fl;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      lvl = (h2 == h3) ? h2 : lprev;
`else
      lvl = h2;
`endif
      rs = lvl && !lprev;
      fl = !lvl && lprev;
      e_valid = 0;
      if (rs) begin
         if (phase == 2) begin
            e_valid  = 1;
            e_high   = 8'(fall_n - rise_n);
            e_period = 8'(n - rise_n);
            e_tmo    = 0;
         end
         phase  = 1;
         rise_n = n;
      end else if (phase != 0 && (n - rise_n) == TMO) begin
         e_tmo = 1;
         phase = 0;
      end else if (fl && phase == 1) begin
         phase  = 2;
         fall_n = n;
      end
      lprev = lvl;
      h3 = h2; h2 = h1; h1 = x;
      n++;
   endtask

   // One clk1ms tick with pwm_in=x, then full output comparison
   task automatic tick(input bit x);
      pwm_in = x;
      @(posedge clk1ms);
      model_step(x);
      #1;
      tests++;
      if (meas_valid !== e_valid) begin
         fails++; $display("FAIL meas_valid n=%0d got %b exp %b", n, meas_valid, e_valid);
      end
      tests++;
      if (high_ticks !== e_high) begin
         fails++; $display("FAIL high_ticks n=%0d got %0d exp %0d", n, high_ticks, e_high);
      end
      tests++;
      if (period_ticks !== e_period) begin
         fails++; $display("FAIL period_ticks n=%0d got %0d exp %0d", n, period_ticks, e_period);
      end
      tests++;
      if (timeout !== e_tmo) begin
         fails++; $display("FAIL timeout n=%0d got %b exp %b", n, timeout, e_tmo);
      end
      tests++;
      if (state !== 2'(phase)) begin
         fails++; $display("FAIL state n=%0d got %0d exp %0d", n, state, phase);
      end
      if (meas_valid === 1'b1) begin
         if (valid_seen == 0) begin first_hi = high_ticks; first_per = period_ticks; end
         last_hi  = high_ticks;
         last_per = period_ticks;
         if (period_ticks < 8'd20) saw_short++;
         valid_seen++;
      end
   endtask

   task automatic run(input bit v, input int k);
      for (int i = 0; i < k; i++) tick(v);
   endtask

   task automatic pulses(input int hi, input int lo, input int cnt);
      for (int i = 0; i < cnt; i++) begin
         run(1'b1, hi);
         run(1'b0, lo);
      end
   endtask

   task automatic clear_stats();
      valid_seen = 0; saw_short = 0;
      first_hi = 0; first_per = 0; last_hi = 0; last_per = 0;
   endtask

   // Asserts reset between clock edges and checks outputs clear immediately
   task automatic apply_reset();
      reset = 1'b1;
      #2;
      model_reset();
      tests++;
      if ({high_ticks, period_ticks} !== 16'h0) begin
         fails++; $display("FAIL reset_counts got %0d/%0d exp 0/0", high_ticks, period_ticks);
      end
      tests++;
      if ({meas_valid, timeout} !== 2'b00) begin
         fails++; $display("FAIL reset_flags got %b%b exp 00", meas_valid, timeout);
      end
      tests++;
      if (state !== 2'b00) begin
         fails++; $display("FAIL reset_state got %0d exp 0", state);
      end
      repeat (2) @(posedge clk1ms);
      #1;
      reset = 1'b0;
      clear_stats();
   endtask

   task automatic test_reset();
      apply_reset();
      run(1'b0, 3);
   endtask

   task automatic test_nominal();
      apply_reset();
      run(1'b0, 5);
      pulses(2, 18, 4);
      tests++;
      if (valid_seen != 3 || last_hi !== 8'd2 || last_per !== 8'd20) begin
         fails++; $display("FAIL nominal got %0d x %0d/%0d exp 3 x 2/20", valid_seen, last_hi, last_per);
      end
   endtask

   task automatic test_duty_change();
      clear_stats();
      pulses(5, 15, 3);
      tests++;
      if (valid_seen != 3 || first_hi !== 8'd2 || last_hi !== 8'd5 || last_per !== 8'd20) begin
         fails++; $display("FAIL duty_change got %0d first %0d last %0d/%0d exp 3 first 2 last 5/20",
                           valid_seen, first_hi, last_hi, last_per);
      end
   endtask

   task automatic test_timeout();
      apply_reset();
      run(1'b0, 5);
      pulses(2, 18, 1);
      run(1'b1, 2);
      run(1'b0, 120);
      tests++;
      if (timeout !== 1'b1 || state !== 2'b00 || high_ticks !== 8'd2 || period_ticks !== 8'd20) begin
         fails++; $display("FAIL timeout_hold got t=%b s=%0d %0d/%0d exp t=1 s=0 2/20",
                           timeout, state, high_ticks, period_ticks);
      end
      pulses(2, 18, 3);
      tests++;
      if (timeout !== 1'b0 || last_hi !== 8'd2 || last_per !== 8'd20) begin
         fails++; $display("FAIL timeout_clear got t=%b %0d/%0d exp t=0 2/20", timeout, last_hi, last_per);
      end
   endtask

   task automatic test_boundary();
      apply_reset();
      run(1'b0, 5);
      pulses(3, 97, 1);
      pulses(3, 98, 1);
      pulses(3, 10, 1);
      tests++;
      if (valid_seen != 1 || first_hi !== 8'd3 || first_per !== 8'd100 || timeout !== 1'b1) begin
         fails++; $display("FAIL boundary got %0d x %0d/%0d t=%b exp 1 x 3/100 t=1",
                           valid_seen, first_hi, first_per, timeout);
      end
   endtask

   task automatic test_high_at_reset();
      pwm_in = 1'b1;
      apply_reset();
      run(1'b1, 5);
      run(1'b0, 10);
      pulses(2, 18, 3);
      tests++;
      if (valid_seen != 2 || first_hi !== 8'd2 || first_per !== 8'd20) begin
         fails++; $display("FAIL high_at_reset got %0d x %0d/%0d exp 2 x 2/20", valid_seen, first_hi, first_per);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      run(1'b0, 5);
      pulses(2, 18, 1);
      run(1'b1, 6);
      tests++;
      if (state !== 2'b01 || high_ticks !== 8'd2) begin
         fails++; $display("FAIL pre_reset got s=%0d hi=%0d exp s=1 hi=2", state, high_ticks);
      end
      apply_reset();
      run(1'b0, 4);
      pulses(2, 18, 2);
      tests++;
      if (valid_seen != 1 || first_per !== 8'd20) begin
         fails++; $display("FAIL reset_mid got %0d x per %0d exp 1 x 20", valid_seen, first_per);
      end
   endtask

   task automatic test_glitch();
      apply_reset();
      run(1'b0, 5);
      pulses(2, 18, 1);
      run(1'b1, 2); run(1'b0, 8); run(1'b1, 1); run(1'b0, 9);
      pulses(2, 18, 2);
      tests++;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      if (saw_short != 0 || valid_seen != 3) begin
         fails++; $display("FAIL glitch got short=%0d n=%0d exp short=0 n=3", saw_short, valid_seen);
      end
`else
      if (saw_short == 0 || valid_seen != 4) begin
         fails++; $display("FAIL glitch got short=%0d n=%0d exp short>0 n=4", saw_short, valid_seen);
      end
`endif
   endtask

   task automatic test_random();
      int hi, lo;
      apply_reset();
      run(1'b0, 5);
      for (int i = 0; i < 40; i++) begin
         hi = $urandom_range(1, 12);
         lo = ($urandom_range(0, 5) == 0) ? $urandom_range(85, 110) : $urandom_range(1, 30);
         pulses(hi, lo, 1);
      end
      run(1'b1, 3);
      run(1'b0, 3);
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_duty_change();
      test_timeout();
      test_boundary();
      test_high_at_reset();
      test_reset_mid();
      test_glitch();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
